// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU client-side arbiters: FSM state encoding and
// FP32 special-value constants.
package fpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_SEND_A = 3'd2,
        ST_SEND_B = 3'd3,
        ST_WAIT_Z = 3'd4,
        ST_RETURN = 3'd5
    } arb_state_t;

    localparam logic [31:0] FP32_QNAN = 32'hFFC00000;
    localparam logic [31:0] FP32_PINF = 32'h7F800000;
    localparam logic [31:0] FP32_NINF = 32'hFF800000;

endpackage

// File: rtl/fpu_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit at or
// after ptr, wrapping modulo N.
module fpu_rr_pick #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    // Scan from the farthest offset down so the nearest hit is assigned last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (int'(ptr) + i >= N) begin
                cand = W'(int'(ptr) + i - N);
            end else begin
                cand = W'(int'(ptr) + i);
            end
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fpu_sub_arbiter.sv
// Shares one stb/ack-handshaked FP32 subtractor among N_REQ requesters with a
// round-robin grant and a single operation in flight.
module fpu_sub_arbiter
    import fpu_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int GRANT_W = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    input  logic [N_REQ-1:0]     req_stb,
    output logic [N_REQ-1:0]     req_ack,
    output logic [31:0]          rsp_z,
    output logic [N_REQ-1:0]     rsp_stb,
    input  logic [N_REQ-1:0]     rsp_ack,
    output logic [31:0]          fu_a,
    output logic                 fu_a_stb,
    input  logic                 fu_a_ack,
    output logic [31:0]          fu_b,
    output logic                 fu_b_stb,
    input  logic                 fu_b_ack,
    input  logic [31:0]          fu_z,
    input  logic                 fu_z_stb,
    output logic                 fu_z_ack,
    output logic                 busy,
    output logic [GRANT_W-1:0]   grant_id,
    output logic [2:0]           fsm_state
);

    // Handshake rule on every stb/ack pair: a word moves at the clock edge where
    // both are high; every stb/ack driven here is a register that drops the
    // cycle after its transfer, and the data it qualifies is stable while high.

    arb_state_t         state, state_d;
    logic [GRANT_W-1:0] rr_ptr, rr_ptr_d, grant_d, pick_idx;
    logic               pick_valid, load_op, load_z;
    logic [N_REQ-1:0]   req_ack_d, rsp_stb_d;
    logic               fu_a_stb_d, fu_b_stb_d, fu_z_ack_d;
    logic [31:0]        sel_a, sel_b;

    fpu_rr_pick #(.N(N_REQ)) u_pick (
        .req   (req_stb),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == GRANT_W'(i)) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d  = state;
        grant_d  = grant_id;
        rr_ptr_d = rr_ptr;
        load_op  = 1'b0;
        load_z   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                // A requester withdrawing before the transfer costs it nothing:
                // rr_ptr is left where it was.
                if (!req_stb[grant_id]) begin
                    state_d = ST_IDLE;
                end else if (req_ack[grant_id]) begin
                    load_op = 1'b1;
                    state_d = ST_SEND_A;
                end
            end
            ST_SEND_A: begin
                if (fu_a_stb && fu_a_ack) state_d = ST_SEND_B;
            end
            ST_SEND_B: begin
                if (fu_b_stb && fu_b_ack) state_d = ST_WAIT_Z;
            end
            ST_WAIT_Z: begin
                if (fu_z_stb && fu_z_ack) begin
                    load_z  = 1'b1;
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (rsp_stb[grant_id] && rsp_ack[grant_id]) begin
                    rr_ptr_d = (grant_id == GRANT_W'(N_REQ - 1)) ? '0 : grant_id + GRANT_W'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // req_ack rises only on the second ACCEPT cycle, giving two edges from
        // req_stb in IDLE to req_ack.
        req_ack_d = '0;
        if (state == ST_ACCEPT && state_d == ST_ACCEPT) req_ack_d[grant_id] = 1'b1;
        rsp_stb_d = '0;
        if (state_d == ST_RETURN) rsp_stb_d[grant_d] = 1'b1;
        fu_a_stb_d = (state_d == ST_SEND_A);
        fu_b_stb_d = (state_d == ST_SEND_B);
        fu_z_ack_d = (state_d == ST_WAIT_Z);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            req_ack  <= '0;
            rsp_stb  <= '0;
            fu_a_stb <= 1'b0;
            fu_b_stb <= 1'b0;
            fu_z_ack <= 1'b0;
        end else begin
            state    <= state_d;
            rr_ptr   <= rr_ptr_d;
            grant_id <= grant_d;
            req_ack  <= req_ack_d;
            rsp_stb  <= rsp_stb_d;
            fu_a_stb <= fu_a_stb_d;
            fu_b_stb <= fu_b_stb_d;
            fu_z_ack <= fu_z_ack_d;
        end
    end

    // Operand and result holding registers are deliberately not reset.
    always_ff @(posedge clk) begin
        if (load_op) begin
            fu_a <= sel_a;
            fu_b <= sel_b;
        end
        if (load_z) rsp_z <= fu_z;
    end

    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

endmodule
